wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl.sv | 71 +++++++
 tb/tb_wptr_full_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-domain side of an async FIFO: binary/Gray write pointer, synchronised
// read pointer, and registered full, almost-full, fill-level and overflow flags.
module wptr_full_ctrl #(
  parameter int data_width = 8,
  parameter int add_width  = 4,
  parameter int af_level   = 12
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_inc,
  input  logic                 ovf_clr,
  input  logic [add_width:0]   r_ptr,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic                 w_overflow,
  output logic [add_width-1:0] w_add,
  output logic [add_width:0]   w_ptr,
  output logic [add_width:0]   w_level
);

  localparam logic [add_width:0] af_thresh = (add_width+1)'(af_level);

  logic [add_width:0] wq1_rptr, wq2_rptr;
  logic [add_width:0] wbin, wbinnext, wgraynext;
  logic [add_width:0] rbin_s, level_next;
  logic               w_accept, full_next;

  assign w_accept  = w_inc & ~w_full;
  assign wbinnext  = wbin + {{add_width{1'b0}}, w_accept};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;
  assign w_add     = wbin[add_width-1:0];

  // Gray-to-binary of the synchronised read pointer, MSB downwards.
  always_comb begin
    rbin_s = '0;
    rbin_s[add_width] = wq2_rptr[add_width];
    for (int i = add_width - 1; i >= 0; i--)
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
  end

  assign level_next = wbinnext - rbin_s;
  // Full when the pointers differ only in the wrap bit (top two Gray bits inverted).
  assign full_next  = (wgraynext == {~wq2_rptr[add_width:add_width-1],
                                     wq2_rptr[add_width-2:0]});

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wq1_rptr      <= '0;
      wq2_rptr      <= '0;
      wbin          <= '0;
      w_ptr         <= '0;
      w_level       <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_overflow    <= 1'b0;
    end else begin
      wq1_rptr      <= r_ptr;
      wq2_rptr      <= wq1_rptr;
      wbin          <= wbinnext;
      w_ptr         <= wgraynext;
      w_level       <= level_next;
      w_full        <= full_next;
      w_almost_full <= (level_next >= af_thresh);
      if (w_inc && w_full)
        w_overflow <= 1'b1;
      else if (ovf_clr)
        w_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed scenarios then random traffic, checked
// against an integer-count model of the FIFO write side.
module tb_wptr_full_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AF    = 12;

  logic          wclk = 1'b0;
  logic          wrst_n, w_inc, ovf_clr;
  logic [AW:0]   r_ptr;
  logic          w_full, w_almost_full, w_overflow;
  logic [AW-1:0] w_add;
  logic [AW:0]   w_ptr, w_level;

  int checks = 0;
  int errors = 0;

  // Model: counts of words written/read, read count as seen 1 and 2 edges late.
  int  m_w, m_r, m_q1, m_q2, m_level;
  bit  m_full, m_af, m_ovf;

  wptr_full_ctrl #(.data_width(8), .add_width(AW), .af_level(AF)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .w_inc(w_inc), .ovf_clr(ovf_clr),
    .r_ptr(r_ptr), .w_full(w_full), .w_almost_full(w_almost_full),
    .w_overflow(w_overflow), .w_add(w_add), .w_ptr(w_ptr), .w_level(w_level)
  );

  always #5 wclk = ~wclk;

  function automatic logic [AW:0] gray(input int b);
    int v;
    v = b % PMOD;
    return (AW+1)'(v ^ (v >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit inc, input bit clr, input bit rst);
    w_inc   = inc;
    ovf_clr = clr;
    wrst_n  = !rst;
    r_ptr   = gray(m_r);
    #1;
    chk("w_add", 32'(w_add), 32'(m_w % DEPTH));
    @(posedge wclk);
    if (rst) begin
      m_w = 0; m_q1 = 0; m_q2 = 0; m_level = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (inc && m_full) m_ovf = 1;
      else if (clr)      m_ovf = 0;
      if (inc && !m_full) m_w = (m_w + 1) % PMOD;
      m_level = (m_w - m_q2 + PMOD) % PMOD;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AF);
      m_q2 = m_q1;
      m_q1 = m_r;
    end
    #1;
    chk("w_full",        32'(w_full),        32'(m_full));
    chk("w_almost_full", 32'(w_almost_full), 32'(m_af));
    chk("w_overflow",    32'(w_overflow),    32'(m_ovf));
    chk("w_level",       32'(w_level),       32'(m_level));
    chk("w_ptr",         32'(w_ptr),         32'(gray(m_w)));
  endtask

  initial begin
    bit wrap_seen;
    logic [AW:0] prev_ptr;
    m_w = 0; m_r = 0; m_q1 = 0; m_q2 = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    w_inc = 0; ovf_clr = 0; wrst_n = 0; r_ptr = '0;

    // Reset, even with write and clear requests present.
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    chk("rst_level", 32'(w_level), 32'd0);
    chk("rst_ptr",   32'(w_ptr),   32'd0);

    // Fill from empty: almost-full on the 12th write, full on the 16th.
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0);
      if (i == 11) chk("af_at_11", 32'(w_almost_full), 32'd0);
      if (i == 12) begin
        chk("af_at_12",    32'(w_almost_full), 32'd1);
        chk("level_at_12", 32'(w_level),       32'd12);
      end
    end
    chk("full_16",  32'(w_full),  32'd1);
    chk("level_16", 32'(w_level), 32'd16);
    chk("ptr_16",   32'(w_ptr),   32'b11000);

    // Overflow: blocked write, clear, and set winning over clear.
    cyc(1, 0, 0);
    chk("ovf_set",     32'(w_overflow), 32'd1);
    chk("ovf_ptr_hold", 32'(w_ptr),     32'b11000);
    chk("ovf_add_hold", 32'(w_add),     32'd0);
    cyc(0, 1, 0);
    chk("ovf_clr", 32'(w_overflow), 32'd0);
    cyc(1, 1, 0);
    chk("ovf_set_wins", 32'(w_overflow), 32'd1);
    cyc(0, 1, 0);

    // One read: full drops exactly on the third edge after r_ptr moves.
    m_r = 1;
    cyc(0, 0, 0);
    chk("rd_lag1", 32'(w_full), 32'd1);
    cyc(0, 0, 0);
    chk("rd_lag2", 32'(w_full), 32'd1);
    cyc(0, 0, 0);
    chk("rd_full_drop",  32'(w_full),  32'd0);
    chk("rd_level_15",   32'(w_level), 32'd15);
    cyc(1, 0, 0);
    chk("refull", 32'(w_full), 32'd1);

    // Long streaming run with the reader trailing by 4: pointer wrap, never full.
    m_r = 0;
    cyc(0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    wrap_seen = 0;
    for (int i = 0; i < 40; i++) begin
      prev_ptr = w_ptr;
      m_r = (m_w - 4 + PMOD) % PMOD;
      cyc(1, 0, 0);
      if (prev_ptr == gray(31) && w_ptr == '0) wrap_seen = 1;
    end
    chk("wrap_seen", 32'(wrap_seen), 32'd1);

    // Reset at level 9 with a write pending; first write afterwards goes to 0.
    m_r = 0;
    cyc(0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0);
    chk("pre_rst_level", 32'(w_level), 32'd9);
    cyc(1, 0, 1);
    chk("mid_rst_level", 32'(w_level), 32'd0);
    chk("mid_rst_add",   32'(w_add),   32'd0);
    cyc(1, 0, 0);
    chk("post_rst_level", 32'(w_level), 32'd1);

    // Random traffic; reader only consumes words actually written.
    for (int i = 0; i < 600; i++) begin
      bit inc, clr, rst;
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if (((m_w - m_r + PMOD) % PMOD) > 0 && $urandom_range(0, 2) == 0)
        m_r = (m_r + 1) % PMOD;
      if (rst) m_r = m_w;
      cyc(inc, clr, rst);
      if (rst) begin
        m_r = 0;
        cyc(0, 0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
